// File: rtl/gift_decrypt_iter_pkg.sv
// Shared definitions for the iterative GIFT-128 decryptor.
// Holds the controller state enum, the inverse S-box, the bit-permutation index table,
// the round-constant helpers and the default round count.
// No ports (package).
package gift_decrypt_iter_pkg;

    localparam int unsigned ROUNDS_DEFAULT = 40;

    typedef enum logic [1:0] {
        StIdle,
        StKexp,
        StDec,
        StDone
    } state_e;

    // Inverse of the GIFT S-box {1,a,4,c,6,f,3,9,2,d,b,7,5,0,8,e}.
    localparam logic [3:0] INV_SBOX [16] = '{
        4'hD, 4'h0, 4'h8, 4'h6, 4'h2, 4'hC, 4'h4, 4'hB,
        4'hE, 4'h7, 4'h1, 4'hA, 4'h3, 4'h9, 4'hF, 4'h5
    };

    // Forward bit positions P(i) for i = 0..15. Each group of 16 source bits shifts the
    // destination up by 4, so P(i) = PERM_BASE[i % 16] + 4 * (i / 16).
    localparam logic [6:0] PERM_BASE [16] = '{
        7'd0,  7'd33, 7'd66, 7'd99, 7'd96, 7'd1,  7'd34, 7'd67,
        7'd64, 7'd97, 7'd2,  7'd35, 7'd32, 7'd65, 7'd98, 7'd3
    };

    // Undoing the permutation means output bit i is read from forward position P(i).
    function automatic logic [6:0] inv_perm_src(input logic [6:0] i);
        return PERM_BASE[i[3:0]] + {2'b00, i[6:4], 2'b00};
    endfunction

    // Round constant used by the last of 'rounds' encryption rounds.
    function automatic logic [5:0] last_rc(input int unsigned rounds);
        logic [5:0] c;
        c = 6'h00;
        for (int unsigned r = 0; r < rounds; r++) begin
            c = {c[4:0], c[5] ^ c[4] ^ 1'b1};
        end
        return c;
    endfunction

    localparam logic [5:0] LAST_RC = last_rc(ROUNDS_DEFAULT);

endpackage

// File: rtl/gift_decrypt_iter_inv_round.sv
// gift_inv_round: one combinational GIFT-128 inverse round.
// Removes the round key and constant, then undoes PermBits and SubCells.
// Ports:
//   i_state [127:0] state entering the inverse round
//   i_rk    [63:0]  round-key bits {U, V}: U = k5||k4, V = k1||k0
//   i_rc    [5:0]   round constant of the round being undone
//   o_state [127:0] state after the inverse round
module gift_inv_round
    import gift_decrypt_iter_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [63:0]  i_rk,
    input  logic [5:0]   i_rc,
    output logic [127:0] o_state
);

    logic [127:0] w_x;
    logic [127:0] w_p;

    always_comb begin
        w_x = i_state;
        for (int i = 0; i < 32; i++) begin
            w_x[4*i+2] = w_x[4*i+2] ^ i_rk[32+i];
            w_x[4*i+1] = w_x[4*i+1] ^ i_rk[i];
        end
        for (int j = 0; j < 6; j++) begin
            w_x[4*j+3] = w_x[4*j+3] ^ i_rc[j];
        end
        w_x[127] = ~w_x[127];

        w_p = '0;
        for (int i = 0; i < 128; i++) begin
            w_p[i] = w_x[inv_perm_src(7'(i))];
        end

        o_state = '0;
        for (int n = 0; n < 32; n++) begin
            o_state[4*n +: 4] = INV_SBOX[w_p[4*n +: 4]];
        end
    end

endmodule

// File: rtl/gift_decrypt_iter.sv
// gift_decrypt_iter: iterative GIFT-128 decryption, one inverse round per cycle.
// The master key is expanded forward to the last round key, then rounds are undone while
// the key schedule and constant LFSR step backward.
// Optional feature: define DEC_KEY_CACHE_EN to keep the last master key and its final round
// key so a repeated key skips expansion.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready job handshake; cipher and key are latched on accept
//   cipher, key       128-bit ciphertext and master key
//   out_valid/out_ready result handshake; plain holds until accepted
//   plain             128-bit recovered plaintext
//   busy              high whenever the controller is not idle
module gift_decrypt_iter
    import gift_decrypt_iter_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cipher,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plain,
    output logic         busy
);

    localparam int unsigned   CW        = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CW-1:0] KEXP_LOAD = CW'(ROUNDS - 2);
    localparam logic [CW-1:0] DEC_LOAD  = CW'(ROUNDS - 1);
    localparam logic [5:0]    RC_LAST   = (ROUNDS == ROUNDS_DEFAULT) ? LAST_RC : last_rc(ROUNDS);

    state_e        r_fsm;
    logic [CW-1:0] r_cnt;
    logic [127:0]  r_key;
    logic [5:0]    r_rc;
    logic [127:0]  r_data;
    logic [127:0]  r_plain;
    logic          r_out_valid;
    logic          r_fin;

    logic [127:0]  w_key_fwd;
    logic [127:0]  w_key_bwd;
    logic [5:0]    w_rc_bwd;
    logic [127:0]  w_round;

    // Forward: k7..k0 <- k1>>>2, k0>>>12, k7..k2 (16-bit words).
    assign w_key_fwd = {r_key[17:16], r_key[31:18], r_key[11:0], r_key[15:12], r_key[127:32]};
    // Backward: exact inverse of the forward step.
    assign w_key_bwd = {r_key[95:0], r_key[125:112], r_key[127:126], r_key[99:96],
                        r_key[111:100]};
    assign w_rc_bwd  = {r_rc[0] ^ r_rc[5] ^ 1'b1, r_rc[5:1]};

    gift_inv_round u_inv_round (
        .i_state (r_data),
        .i_rk    ({r_key[95:64], r_key[31:0]}),
        .i_rc    (r_rc),
        .o_state (w_round)
    );

`ifdef DEC_KEY_CACHE_EN
    logic         r_cache_vld;
    logic [127:0] r_cache_key;
    logic [127:0] r_cache_rk;
    logic         w_hit;

    assign w_hit = r_cache_vld && (r_cache_key == key);
`endif

    assign in_ready  = (r_fsm == StIdle);
    assign busy      = (r_fsm != StIdle);
    assign out_valid = r_out_valid;
    assign plain     = r_plain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= StIdle;
            r_cnt       <= '0;
            r_key       <= '0;
            r_rc        <= '0;
            r_data      <= '0;
            r_plain     <= '0;
            r_out_valid <= 1'b0;
            r_fin       <= 1'b0;
`ifdef DEC_KEY_CACHE_EN
            r_cache_vld <= 1'b0;
            r_cache_key <= '0;
            r_cache_rk  <= '0;
`endif
        end else begin
            unique case (r_fsm)
                StIdle: begin
                    if (in_valid) begin
                        r_data <= cipher;
                        r_fin  <= 1'b0;
`ifdef DEC_KEY_CACHE_EN
                        if (w_hit) begin
                            r_key <= r_cache_rk;
                            r_rc  <= RC_LAST;
                            r_cnt <= DEC_LOAD;
                            r_fsm <= StDec;
                        end else begin
                            // Cache entry is rewritten once this expansion completes.
                            r_cache_vld <= 1'b0;
                            r_cache_key <= key;
                            r_key       <= key;
                            r_cnt       <= KEXP_LOAD;
                            r_fsm       <= StKexp;
                        end
`else
                        r_key <= key;
                        r_cnt <= KEXP_LOAD;
                        r_fsm <= StKexp;
`endif
                    end
                end
                StKexp: begin
                    r_key <= w_key_fwd;
                    if (r_cnt == '0) begin
                        r_rc  <= RC_LAST;
                        r_cnt <= DEC_LOAD;
                        r_fsm <= StDec;
`ifdef DEC_KEY_CACHE_EN
                        r_cache_rk  <= w_key_fwd;
                        r_cache_vld <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StDec: begin
                    // After the last inverse round one more cycle moves the state into the
                    // output register, so plain never exposes an intermediate round.
                    if (r_fin) begin
                        r_plain     <= r_data;
                        r_out_valid <= 1'b1;
                        r_fsm       <= StDone;
                    end else begin
                        r_data <= w_round;
                        r_key  <= w_key_bwd;
                        r_rc   <= w_rc_bwd;
                        if (r_cnt == '0) begin
                            r_fin <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_fsm       <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gift_decrypt_iter.sv
module tb_gift_decrypt_iter;

    localparam int R = 40;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] cipher;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plain;
    logic         busy;

    gift_decrypt_iter #(.ROUNDS(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cipher    (cipher),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .plain     (plain),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference encryption: GIFT-128 built from the published S-box, bit-permutation
    // formula and round-constant list.
    localparam logic [3:0] GS [16] = '{
        4'h1, 4'hA, 4'h4, 4'hC, 4'h6, 4'hF, 4'h3, 4'h9,
        4'h2, 4'hD, 4'hB, 4'h7, 4'h5, 4'h0, 4'h8, 4'hE
    };
    localparam logic [5:0] RC_TAB [40] = '{
        6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
        6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
        6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
        6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
    };

    function automatic int perm_pos(input int i);
        return 4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
    endfunction

    function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
        return (x >> n) | (x << (16 - n));
    endfunction

    function automatic logic [127:0] gift_enc(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] s;
        logic [127:0] t;
        logic [15:0]  w  [8];
        logic [15:0]  nw [8];
        logic [31:0]  u;
        logic [31:0]  v;
        logic [5:0]   c;
        s = pt;
        for (int j = 0; j < 8; j++) w[j] = k[16*j +: 16];
        for (int r = 0; r < R; r++) begin
            for (int n = 0; n < 32; n++) s[4*n +: 4] = GS[s[4*n +: 4]];
            t = '0;
            for (int i = 0; i < 128; i++) t[perm_pos(i)] = s[i];
            s = t;
            u = {w[5], w[4]};
            v = {w[1], w[0]};
            for (int i = 0; i < 32; i++) begin
                s[4*i+2] = s[4*i+2] ^ u[i];
                s[4*i+1] = s[4*i+1] ^ v[i];
            end
            c = RC_TAB[r];
            for (int j = 0; j < 6; j++) s[4*j+3] = s[4*j+3] ^ c[j];
            s[127] = ~s[127];
            nw[7] = rotr16(w[1], 2);
            nw[6] = rotr16(w[0], 12);
            for (int j = 0; j < 6; j++) nw[j] = w[j+2];
            w = nw;
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    typedef struct {
        logic [127:0] pt;
        int           lat;
    } exp_t;

    exp_t sb_q [$];
    int   acc_q [$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

`ifdef DEC_KEY_CACHE_EN
    bit           m_cache_vld = 1'b0;
    logic [127:0] m_cache_key = '0;
`endif

    function automatic int expected_latency(input logic [127:0] k);
`ifdef DEC_KEY_CACHE_EN
        if (m_cache_vld && m_cache_key == k) return R + 1;
        m_cache_vld = 1'b1;
        m_cache_key = k;
`endif
        return 2 * R;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic note_timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) acc_q.push_back(cyc + 1);
    end

    // Monitor: pops the scoreboard when a result appears, checks it stays put while stalled.
    initial begin
        logic         prev;
        logic [127:0] held;
        exp_t         e;
        int           a;
        prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (out_valid && !prev) begin
                    if (sb_q.size() == 0 || acc_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_out: out_valid with plain %h, none expected",
                                 plain);
                    end else begin
                        e = sb_q.pop_front();
                        a = acc_q.pop_front();
                        check("plain", plain, e.pt);
                        check("latency", 128'(cyc - a), 128'(e.lat));
                    end
                    held = plain;
                end else if (out_valid && prev) begin
                    check("plain_hold", plain, held);
                    check("in_ready_in_done", {127'b0, in_ready}, 128'd0);
                end
                prev = out_valid;
            end
        end
    end

    task automatic run_job(input logic [127:0] pt, input logic [127:0] k, input bit garbage,
                           input int hold_cycles);
        exp_t e;
        int   t;
        t = 0;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            note_timeout("wait_in_ready");
            return;
        end
        e.pt  = pt;
        e.lat = expected_latency(k);
        sb_q.push_back(e);
        in_valid  = 1'b1;
        cipher    = gift_enc(pt, k);
        key       = k;
        out_ready = (hold_cycles == 0);
        @(negedge clk);
        if (garbage) begin
            cipher = rnd128();
            key    = rnd128();
        end else begin
            in_valid = 1'b0;
        end
        t = 0;
        while (!out_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            note_timeout("wait_out_valid");
            out_ready = 1'b1;
            return;
        end
        for (int i = 0; i < hold_cycles; i++) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k;
        logic [127:0] last_k;
        bit           saw_valid;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        cipher    = '0;
        key       = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {127'b0, in_ready}, 128'd1);
        check("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("rst_busy", {127'b0, busy}, 128'd0);
        check("rst_plain", plain, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero key, zero plaintext.
        run_job(128'd0, 128'd0, 1'b0, 0);
        // Counting key, all-ones plaintext.
        run_job({128{1'b1}}, 128'h000102030405060708090A0B0C0D0E0F, 1'b0, 0);

        // Stalled consumer, then an immediate follow-on accept.
        run_job(rnd128(), rnd128(), 1'b0, 10);
        check("ready_after_handshake", {127'b0, in_ready}, 128'd1);
        run_job(rnd128(), rnd128(), 1'b0, 0);

        // Inputs offered while busy must be ignored.
        run_job(rnd128(), rnd128(), 1'b1, 0);

        // Reset in the middle of a job.
        in_valid = 1'b1;
        cipher   = rnd128();
        key      = rnd128();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        acc_q.delete();
`ifdef DEC_KEY_CACHE_EN
        m_cache_vld = 1'b0;
`endif
        @(negedge clk);
        check("midrst_busy", {127'b0, busy}, 128'd0);
        check("midrst_plain", plain, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", {127'b0, in_ready}, 128'd1);
        saw_valid = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("postrst_no_valid", {127'b0, saw_valid}, 128'd0);

        // Same key twice, then a new key.
        k = rnd128();
        run_job(rnd128(), k, 1'b0, 0);
        run_job(rnd128(), k, 1'b0, 0);
        run_job(rnd128(), ~k, 1'b0, 0);

        // Random key/plaintext pairs, with some key reuse and busy-time noise.
        last_k = ~k;
        for (int i = 0; i < 1000; i++) begin
            k = ($urandom_range(0, 2) == 0) ? last_k : rnd128();
            run_job(rnd128(), k, ($urandom_range(0, 3) == 0), 0);
            last_k = k;
        end

        repeat (5) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d results never appeared", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
